// File: rtl/serv_bus_arb_if.sv
// serv_bus_arb_if
// Bundles the three bus faces of the ibus/dbus arbiter into one interface:
//   ibus   : i_ibus_adr, i_ibus_cyc -> o_ibus_rdt, o_ibus_ack
//   dbus   : i_dbus_adr/dat/sel/we/cyc -> o_dbus_rdt, o_dbus_ack
//   wb     : o_wb_adr/dat/sel/we/cyc <- i_wb_rdt, i_wb_ack
//   status : o_timeout (watchdog termination pulse)
// Signal names carry the arbiter's point of view (i_ = into the arbiter).
// Modports:
//   slave  - taken by the arbiter itself (serves both masters)
//   master - taken by whatever drives the arbiter (core + memory model)
interface serv_bus_arb_if;
    logic [31:0] i_ibus_adr;
    logic        i_ibus_cyc;
    logic [31:0] o_ibus_rdt;
    logic        o_ibus_ack;

    logic [31:0] i_dbus_adr;
    logic [31:0] i_dbus_dat;
    logic [3:0]  i_dbus_sel;
    logic        i_dbus_we;
    logic        i_dbus_cyc;
    logic [31:0] o_dbus_rdt;
    logic        o_dbus_ack;

    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we;
    logic        o_wb_cyc;
    logic [31:0] i_wb_rdt;
    logic        i_wb_ack;

    logic        o_timeout;

    modport slave (
        input  i_ibus_adr, i_ibus_cyc,
        output o_ibus_rdt, o_ibus_ack,
        input  i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc,
        output o_dbus_rdt, o_dbus_ack,
        output o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc,
        input  i_wb_rdt, i_wb_ack,
        output o_timeout
    );

    modport master (
        output i_ibus_adr, i_ibus_cyc,
        input  o_ibus_rdt, o_ibus_ack,
        output i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc,
        input  o_dbus_rdt, o_dbus_ack,
        input  o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc,
        output i_wb_rdt, i_wb_ack,
        input  o_timeout
    );
endinterface

// File: rtl/serv_bus_arb.sv
// serv_bus_arb
// Shares one Wishbone slave port between the instruction bus and the data
// bus. One master is granted at a time and the grant is held until the slave
// acks, the watchdog expires, or the granted master abandons its cycle.
// dbus wins simultaneous requests unless ibus has already lost STARVE_MAX
// times in a row. Every change of owner passes through IDLE.
// Ports:
//   clk   - system clock, rising edge
//   i_rst - synchronous active-high reset
//   bus   - serv_bus_arb_if.slave carrying ibus, dbus, wb and o_timeout
// Parameters:
//   TIMEOUT_W  - watchdog width; a grant is cut off at grant cycle 2^W-1
//   STARVE_MAX - consecutive dbus wins tolerated while ibus waits (1..7)
module serv_bus_arb #(
    parameter int TIMEOUT_W  = 8,
    parameter int STARVE_MAX = 2
) (
    input  logic                clk,
    input  logic                i_rst,
    serv_bus_arb_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    localparam logic [2:0]           STARVE_LIM = 3'(STARVE_MAX);
    localparam logic [TIMEOUT_W-1:0] WDOG_MAX   = {TIMEOUT_W{1'b1}};
    localparam logic [TIMEOUT_W-1:0] WDOG_ONE   = TIMEOUT_W'(1);

    state_t               state_r;
    logic [2:0]           starve_r;
    logic [TIMEOUT_W-1:0] wdog_r;

    logic gnt_i_s;
    logic gnt_d_s;
    logic owner_cyc_s;
    logic wdog_max_s;
    logic expire_s;
    logic fwd_ack_s;
    logic done_s;

    // Grant decode, watchdog expiry and termination conditions
    always_comb begin
        gnt_i_s    = (state_r == GNT_I);
        gnt_d_s    = (state_r == GNT_D);
        wdog_max_s = (wdog_r == WDOG_MAX);
        if (gnt_d_s) begin
            owner_cyc_s = bus.i_dbus_cyc;
        end else if (gnt_i_s) begin
            owner_cyc_s = bus.i_ibus_cyc;
        end else begin
            owner_cyc_s = 1'b0;
        end
        // A real ack on the expiry cycle wins, so expiry needs ~ack.
        // Nothing is forwarded during reset or to a master that has let go.
        expire_s  = owner_cyc_s & wdog_max_s & ~bus.i_wb_ack & ~i_rst;
        fwd_ack_s = owner_cyc_s & (bus.i_wb_ack | wdog_max_s) & ~i_rst;
        done_s    = bus.i_wb_ack | wdog_max_s | ~owner_cyc_s;
    end

    // Slave-side and master-side output muxing
    always_comb begin
        bus.o_wb_cyc = gnt_i_s | gnt_d_s;
        bus.o_wb_dat = bus.i_dbus_dat;
        if (gnt_d_s) begin
            bus.o_wb_adr = bus.i_dbus_adr;
            bus.o_wb_sel = bus.i_dbus_sel;
            bus.o_wb_we  = bus.i_dbus_we;
        end else begin
            bus.o_wb_adr = bus.i_ibus_adr;
            bus.o_wb_sel = 4'hF;
            bus.o_wb_we  = 1'b0;
        end
        bus.o_ibus_ack = fwd_ack_s & gnt_i_s;
        bus.o_dbus_ack = fwd_ack_s & gnt_d_s;
        if (expire_s) begin
            bus.o_ibus_rdt = 32'h0000_0000;
            bus.o_dbus_rdt = 32'h0000_0000;
        end else begin
            bus.o_ibus_rdt = bus.i_wb_rdt;
            bus.o_dbus_rdt = bus.i_wb_rdt;
        end
        bus.o_timeout = expire_s;
    end

    // Grant state machine with starvation counter and watchdog
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_r  <= IDLE;
            starve_r <= 3'd0;
            wdog_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    wdog_r <= '0;
                    if (bus.i_dbus_cyc && (!bus.i_ibus_cyc || (starve_r != STARVE_LIM))) begin
                        state_r <= GNT_D;
                        // Only a dbus win that leaves ibus waiting counts.
                        if (bus.i_ibus_cyc && (starve_r < STARVE_LIM)) begin
                            starve_r <= starve_r + 3'd1;
                        end else begin
                            starve_r <= starve_r;
                        end
                    end else if (bus.i_ibus_cyc) begin
                        state_r  <= GNT_I;
                        starve_r <= 3'd0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GNT_I, GNT_D: begin
                    if (done_s) begin
                        state_r <= IDLE;
                        wdog_r  <= '0;
                    end else begin
                        wdog_r <= wdog_r + WDOG_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    wdog_r  <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/serv_bus_arb.md
# serv_bus_arb

Registered two-master arbiter that shares one Wishbone slave port between the core's instruction bus (ibus) and data bus (dbus). It sits between the core top level and a single-ported memory or interconnect. It grants one master at a time through a small state machine and holds the grant until the slave acks. It applies dbus-first priority with an anti-starvation limit for ibus, and a watchdog that terminates cycles the slave never acks.

## Interface
Parameters:
- TIMEOUT_W, default 8: width of the watchdog counter; a granted cycle times out after 2^TIMEOUT_W-1 cycles without ack.
- STARVE_MAX, default 2, range 1..7: maximum consecutive dbus grants while ibus waits.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- i_rst  in  1  reset. Synchronous, active-high.
- i_ibus_adr  in  32  ibus address.
- i_ibus_cyc  in  1  ibus request.
- o_ibus_rdt  out  32  ibus read data.
- o_ibus_ack  out  1  ibus ack, one cycle.
- i_dbus_adr  in  32  dbus address.
- i_dbus_dat  in  32  dbus write data.
- i_dbus_sel  in  4  dbus byte enables.
- i_dbus_we  in  1  dbus write enable.
- i_dbus_cyc  in  1  dbus request.
- o_dbus_rdt  out  32  dbus read data.
- o_dbus_ack  out  1  dbus ack, one cycle.
- o_wb_adr  out  32  slave address.
- o_wb_dat  out  32  slave write data.
- o_wb_sel  out  4  slave byte enables.
- o_wb_we  out  1  slave write enable.
- o_wb_cyc  out  1  slave cycle.
- i_wb_rdt  in  32  slave read data.
- i_wb_ack  in  1  slave ack.
- o_timeout  out  1  one-cycle pulse when the watchdog terminates a cycle.

## Operation
- State machine with three states: IDLE, GNT_I, GNT_D. The state resets to IDLE.
- Transitions out of IDLE:
  - Only dbus requests: go to GNT_D.
  - Only ibus requests: go to GNT_I.
  - Both request: go to GNT_D, unless the starve counter equals STARVE_MAX; then go to GNT_I.
  - Neither requests: stay in IDLE.
- GNT_x returns to IDLE on any of these:
  - i_wb_ack is high.
  - The watchdog expires.
  - The granted master's cyc drops (abandoned cycle; no ack is forwarded).
- A grant never transfers directly between masters. Every change of owner passes through IDLE.
- Starve counter, 3 bits:
  - +1 on entry to GNT_D while i_ibus_cyc is high.
  - Cleared on entry to GNT_I.
  - Saturates at STARVE_MAX.
  - Reset value 0.
- Slave-side outputs:
  - o_wb_cyc = state != IDLE.
  - o_wb_adr = i_dbus_adr in GNT_D, otherwise i_ibus_adr.
  - o_wb_dat = i_dbus_dat.
  - o_wb_sel = i_dbus_sel in GNT_D, otherwise 4'hF.
  - o_wb_we = i_dbus_we only in GNT_D, otherwise 0.
- Master-side outputs:
  - o_ibus_ack = i_wb_ack & GNT_I.
  - o_dbus_ack = i_wb_ack & GNT_D.
  - o_ibus_rdt and o_dbus_rdt pass i_wb_rdt through.
  - On a timeout the terminated master receives ack = 1 and rdt = 0.
- Watchdog:
  - Counter is cleared in IDLE and increments each cycle in GNT_x without ack.
  - Expiry: counter == 2^TIMEOUT_W-1 with no ack in that cycle. In that cycle o_timeout = 1 and the granted master receives its forced ack.
  - If ack and expiry fall in the same cycle, the real ack wins and o_timeout stays 0.
- Reset values: state IDLE, o_wb_cyc 0, o_wb_we 0, both master acks 0, o_timeout 0, all counters 0. Data and address outputs are don't-care while o_wb_cyc is 0.
- Reset asserted mid-cycle: the next clock edge forces IDLE and drops o_wb_cyc. Any ack arriving in the reset cycle is not forwarded.

## Timing
- Request latency:
  - A master raises cyc in cycle N with the arbiter in IDLE.
  - The grant state is entered at N+1; o_wb_cyc is high from N+1.
- Ack is combinational from slave to master in the same cycle M.
- The arbiter is back in IDLE at M+1.
- The earliest next grant is M+2. The master drops cyc at M+1, so a stale request is never re-granted.
- Minimum cost is 2 arbiter cycles per transfer plus slave latency.
- Masters must hold adr, dat, sel and we stable while cyc is high; the arbiter does not register them.
- Timeout terminates at grant cycle 2^TIMEOUT_W-1 counting from the grant cycle as 0. This is cycle 255 with the default.

## Test plan
- Single ibus read:
  - Stimulus: ibus cyc at cycle 0 with adr 0x8; slave acks at cycle 3 with rdt 0xDEADBEEF.
  - Required: o_wb_cyc high in cycles 1-3; o_ibus_ack at 3 with rdt 0xDEADBEEF; state IDLE at 4; o_dbus_ack never asserts.
- Simultaneous requests:
  - Stimulus: ibus and dbus both raise cyc in cycle 0.
  - Required: dbus is granted first with o_wb_we and sel following dbus; ibus is granted only after dbus acks plus one IDLE cycle; o_wb_sel is 4'hF during the ibus grant.
- Starvation, STARVE_MAX=2:
  - Stimulus: dbus re-requests continuously while ibus holds cyc high.
  - Required: exactly 2 dbus grants, then an ibus grant, then the counter is 0.
- Watchdog, TIMEOUT_W=3:
  - Stimulus: dbus request, slave never acks.
  - Required: in grant cycle 7, o_timeout = 1, o_dbus_ack = 1, o_dbus_rdt = 0; o_wb_cyc low the next cycle.
- Ack on the expiry cycle:
  - Stimulus: slave acks in exactly the expiry cycle, with TIMEOUT_W=3.
  - Required: o_timeout stays 0 and the master receives i_wb_rdt.
- Reset mid-grant and abandoned cycle:
  - Stimulus A: assert i_rst during GNT_D with ack arriving in the same cycle.
  - Required A: no o_dbus_ack; o_wb_cyc is 0 the next cycle.
  - Stimulus B: the granted master drops cyc before any ack.
  - Required B: return to IDLE the next cycle with no ack forwarded.
